lru_victim_select: RTL and testbench



---
 rtl/lru_victim_select_if.sv | 30 +++
 rtl/lru_victim_select.sv | 129 ++++++++++++
 tb/tb_lru_victim_select.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/lru_victim_select_if.sv
// Request/response bundle between the cache controller and the LRU victim selector.
// The master drives hit updates, miss requests and fill completion; the slave answers.
interface lru_victim_select_if #(
    parameter int WAY  = 4,
    parameter int SETS = 16
);
    localparam int CW = $clog2(WAY);
    localparam int SW = $clog2(SETS);

    logic          hit_valid;
    logic [SW-1:0] hit_set;
    logic [CW-1:0] hit_way;
    logic          miss_valid;
    logic          miss_ready;
    logic [SW-1:0] miss_set;
    logic          victim_valid;
    logic [CW-1:0] victim_way;
    logic          fill_done;
    logic          busy;

    modport master (
        output hit_valid, hit_set, hit_way, miss_valid, miss_set, fill_done,
        input  miss_ready, victim_valid, victim_way, busy
    );

    modport slave (
        input  hit_valid, hit_set, hit_way, miss_valid, miss_set, fill_done,
        output miss_ready, victim_valid, victim_way, busy
    );
endinterface

// File: rtl/lru_victim_select.sv
// Per-set LRU age counters with miss-side victim selection; sole owner of LRU state.
// Ages: 0 = least recently used, WAY-1 = most recently used; each set is a permutation.
module lru_victim_select #(
    parameter int WAY  = 4,
    parameter int SETS = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    lru_victim_select_if.slave   bus
);
    localparam int CW = $clog2(WAY);
    localparam int SW = $clog2(SETS);

    typedef logic [WAY-1:0][CW-1:0] row_t;
    typedef enum logic [1:0] {IDLE, LOOKUP, WAIT_FILL} state_t;

    state_t        state_reg, state_next;
    row_t          age_reg  [SETS];
    row_t          age_next [SETS];
    logic [SW-1:0] set_reg;
    logic [CW-1:0] victim_reg;
    logic [CW-1:0] lookup_way;
    logic [CW-1:0] lookup_min;
    row_t          lookup_row;
    logic          fill_fire;
    logic          hit_apply;

    // Promote one way to MRU; ways younger than it shift down one step.
    function automatic row_t update_row(input row_t row, input logic [CW-1:0] way);
        row_t          r;
        logic [CW-1:0] c;
        r = row;
        c = row[way];
        for (int w = 0; w < WAY; w++) begin
            if (CW'(w) == way)
                r[w] = CW'(WAY - 1);
            else if (row[w] > c)
                r[w] = row[w] - CW'(1);
        end
        return r;
    endfunction

    assign fill_fire = (state_reg == WAIT_FILL) && bus.fill_done;
    // A hit on the set being filled in the same cycle loses to the fill.
    assign hit_apply = bus.hit_valid && !(fill_fire && (bus.hit_set == set_reg));

    generate
        for (genvar gi = 0; gi < SETS; gi++) begin : g_set
            logic fill_here;
            logic hit_here;
            assign fill_here = fill_fire && (set_reg == SW'(gi));
            assign hit_here  = hit_apply && (bus.hit_set == SW'(gi));
            assign age_next[gi] = fill_here ? update_row(age_reg[gi], victim_reg) :
                                  hit_here  ? update_row(age_reg[gi], bus.hit_way) :
                                              age_reg[gi];
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAY; w++)
                    age_reg[s][w] <= CW'(w);
        end else begin
            for (int s = 0; s < SETS; s++)
                age_reg[s] <= age_next[s];
        end
    end

    // Lowest-index minimum: the age-0 way in a healthy set, a sane pick if corrupted.
    always_comb begin
        lookup_row = age_reg[set_reg];
        lookup_min = lookup_row[0];
        lookup_way = '0;
        for (int w = 1; w < WAY; w++) begin
            if (lookup_row[w] < lookup_min) begin
                lookup_min = lookup_row[w];
                lookup_way = CW'(w);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next       = state_reg;
        bus.miss_ready   = 1'b0;
        bus.victim_valid = 1'b0;
        bus.busy         = 1'b1;
        case (state_reg)
            IDLE: begin
                bus.miss_ready = 1'b1;
                bus.busy       = 1'b0;
                if (bus.miss_valid)
                    state_next = LOOKUP;
            end
            LOOKUP: begin
                state_next = WAIT_FILL;
            end
            WAIT_FILL: begin
                bus.victim_valid = 1'b1;
                if (bus.fill_done)
                    state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            set_reg    <= '0;
            victim_reg <= '0;
        end else begin
            if (state_reg == IDLE && bus.miss_valid)
                set_reg <= bus.miss_set;
            if (state_reg == LOOKUP)
                victim_reg <= lookup_way;
        end
    end

    assign bus.victim_way = victim_reg;
endmodule

// File: tb/tb_lru_victim_select.sv
// Directed bench for lru_victim_select: hand-computed victims and per-set age rows.
module tb_lru_victim_select;
    localparam int WAY  = 4;
    localparam int SETS = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    lru_victim_select_if #(.WAY(WAY), .SETS(SETS)) bus ();

    lru_victim_select #(.WAY(WAY), .SETS(SETS)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Packed row as stored: way0 in the low bits.
    function automatic logic [7:0] row4(input int a0, input int a1, input int a2, input int a3);
        logic [1:0] b0, b1, b2, b3;
        b0 = a0[1:0]; b1 = a1[1:0]; b2 = a2[1:0]; b3 = a3[1:0];
        return {b3, b2, b1, b0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.hit_valid  = 1'b0;
        bus.hit_set    = '0;
        bus.hit_way    = '0;
        bus.miss_valid = 1'b0;
        bus.miss_set   = '0;
        bus.fill_done  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic check_row(input string tag, input int s, input logic [7:0] exp);
        check(tag, 32'(dut.age_reg[s]), 32'(exp));
    endtask

    // Accept a miss, then check the LOOKUP cycle and the presented victim.
    task automatic miss(input string tag, input int s, input int exp_victim);
        check({tag, " ready"}, 32'(bus.miss_ready), 32'd1);
        bus.miss_valid = 1'b1;
        bus.miss_set   = 4'(s);
        tick();
        bus.miss_valid = 1'b0;
        bus.hit_valid  = 1'b0;
        check({tag, " lookup vv"}, 32'(bus.victim_valid), 32'd0);
        check({tag, " lookup busy"}, 32'(bus.busy), 32'd1);
        tick();
        check({tag, " vv"}, 32'(bus.victim_valid), 32'd1);
        check({tag, " way"}, 32'(bus.victim_way), 32'(exp_victim));
        $display("miss set=%0d victim=%0d", s, bus.victim_way);
    endtask

    task automatic fill(input string tag);
        bus.fill_done = 1'b1;
        tick();
        bus.fill_done = 1'b0;
        bus.hit_valid = 1'b0;
        check({tag, " post vv"}, 32'(bus.victim_valid), 32'd0);
        check({tag, " post ready"}, 32'(bus.miss_ready), 32'd1);
        $display("fill done");
    endtask

    initial begin
        int          exp_v [5];
        logic [7:0]  exp_r [4];
        exp_v = '{0, 1, 2, 3, 0};
        exp_r[0] = row4(3, 0, 1, 2);
        exp_r[1] = row4(2, 3, 0, 1);
        exp_r[2] = row4(1, 2, 3, 0);
        exp_r[3] = row4(0, 1, 2, 3);

        // Reset state
        idle_inputs();
        #2;
        check("rst ready", 32'(bus.miss_ready), 32'd1);
        check("rst vv", 32'(bus.victim_valid), 32'd0);
        check("rst way", 32'(bus.victim_way), 32'd0);
        check("rst busy", 32'(bus.busy), 32'd0);
        do_reset();
        check_row("rst row0", 0, row4(0, 1, 2, 3));
        check_row("rst row15", 15, row4(0, 1, 2, 3));

        // Single miss on set 5, fill two cycles after the victim appears
        miss("t1", 5, 0);
        tick();
        check("t1 hold vv", 32'(bus.victim_valid), 32'd1);
        check("t1 hold way", 32'(bus.victim_way), 32'd0);
        fill("t1");
        check_row("t1 row5", 5, row4(3, 0, 1, 2));

        // Round-robin victims on set 7
        do_reset();
        for (int i = 0; i < 5; i++) begin
            miss($sformatf("t2 m%0d", i), 7, exp_v[i]);
            if (i < 4) begin
                fill($sformatf("t2 f%0d", i));
                check_row($sformatf("t2 row7 %0d", i), 7, exp_r[i]);
            end
        end
        fill("t2 f4");

        // Hits steer the victim on set 2
        do_reset();
        bus.hit_valid = 1'b1; bus.hit_set = 4'd2; bus.hit_way = 2'd0;
        tick();
        check_row("t3 hit w0", 2, row4(3, 0, 1, 2));
        bus.hit_way = 2'd3;
        tick();
        bus.hit_valid = 1'b0;
        check_row("t3 hit w3", 2, row4(2, 0, 1, 3));
        miss("t3", 2, 1);
        fill("t3");
        check_row("t3 row2", 2, row4(1, 3, 0, 2));

        // Hit on the victim during WAIT_FILL; fill then leaves the row alone
        do_reset();
        miss("t4", 0, 0);
        bus.hit_valid = 1'b1; bus.hit_set = 4'd0; bus.hit_way = 2'd0;
        tick();
        bus.hit_valid = 1'b0;
        check_row("t4 hit", 0, row4(3, 0, 1, 2));
        fill("t4");
        check_row("t4 fill", 0, row4(3, 0, 1, 2));
        miss("t4b", 0, 1);
        fill("t4b");
        check_row("t4b row0", 0, row4(2, 3, 0, 1));

        // Fill and hit together: same set drops the hit, other set keeps it
        do_reset();
        miss("t5", 4, 0);
        bus.hit_valid = 1'b1; bus.hit_set = 4'd4; bus.hit_way = 2'd2;
        fill("t5");
        check_row("t5 row4", 4, row4(3, 0, 1, 2));
        miss("t5b", 4, 1);
        bus.hit_valid = 1'b1; bus.hit_set = 4'd9; bus.hit_way = 2'd2;
        fill("t5b");
        check_row("t5b row4", 4, row4(2, 3, 0, 1));
        check_row("t5b row9", 9, row4(0, 1, 3, 2));

        // Hit and miss accept on the same set in IDLE: lookup sees the hit
        do_reset();
        bus.hit_valid = 1'b1; bus.hit_set = 4'd3; bus.hit_way = 2'd0;
        miss("t6", 3, 1);
        fill("t6");
        check_row("t6 row3", 3, row4(2, 3, 0, 1));

        // Asynchronous reset while waiting for a fill
        do_reset();
        bus.hit_valid = 1'b1; bus.hit_set = 4'd1; bus.hit_way = 2'd0;
        tick();
        bus.hit_valid = 1'b0;
        check_row("t7 pre row1", 1, row4(3, 0, 1, 2));
        miss("t7", 6, 0);
        #2;
        rst = 1'b1;
        #1;
        check("t7 rst vv", 32'(bus.victim_valid), 32'd0);
        check("t7 rst busy", 32'(bus.busy), 32'd0);
        check("t7 rst ready", 32'(bus.miss_ready), 32'd1);
        for (int s = 0; s < SETS; s++)
            check_row($sformatf("t7 row%0d", s), s, row4(0, 1, 2, 3));
        tick();
        rst = 1'b0;
        bus.fill_done = 1'b1;
        tick();
        bus.fill_done = 1'b0;
        check_row("t7 stray fill row6", 6, row4(0, 1, 2, 3));
        check("t7 stray fill busy", 32'(bus.busy), 32'd0);
        check("t7 stray fill vv", 32'(bus.victim_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
